// File: rtl/alu_pkg.sv
// Shared constants for the ALU self-test engine: op codes, FSM encoding, LFSR taps.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_DRIVE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/lfsr_step2.sv
// Combinational double step of a right-shifting Galois LFSR; both intermediate states are exposed.
module lfsr_step2
    import alu_pkg::*;
#(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] step1_o,
    output logic [WIDTH-1:0] step2_o
);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign step1_o = step(state_i);
    assign step2_o = step(step1_o);

endmodule

// File: rtl/alu_bist.sv
// Self-test engine for the 32-bit ALU: drives LFSR operands with a fixed op,
// checks z against a reference model and keeps pass/fail counts plus the first failure.
module alu_bist
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8,
    parameter bit SLT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    output logic             busy,
    output logic             done,
    output logic             op_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_z,
    output logic [2:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fz_q, fz_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] step1, step2, expect_z;

    lfsr_step2 #(.WIDTH(WIDTH)) u_lfsr (
        .state_i (lfsr_q),
        .step1_o (step1),
        .step2_o (step2)
    );

    // Reference result for the operands currently on the ALU.
    always_comb begin
        expect_z = '0;
        case (op_q)
            OP_AND:  expect_z = a_q & b_q;
            OP_OR:   expect_z = a_q | b_q;
            OP_ADD:  expect_z = a_q + b_q;
            OP_SUB:  expect_z = a_q - b_q;
            OP_SLT:  expect_z = SLT_EN ? WIDTH'($signed(a_q) < $signed(b_q)) : '0;
            default: expect_z = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        left_d  = left_q;
        lfsr_d  = lfsr_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fz_d    = fz_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d   = op_sel;
                    left_d = num_vec;
                    lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
                    pass_d = '0;
                    fail_d = '0;
                    fa_d   = '0;
                    fb_d   = '0;
                    fz_d   = '0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (!op_valid(op_sel)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (num_vec == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                a_d     = step1;
                b_d     = step2;
                lfsr_d  = step2;
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                z_d     = alu_z;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (z_q == expect_z) begin
                    pass_d = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
                end else begin
                    if (fail_q == '0) begin
                        fa_d = a_q;
                        fb_d = b_q;
                        fz_d = z_q;
                    end
                    fail_d = (fail_q == '1) ? fail_q : fail_q + CNT_W'(1);
                end
                left_d = left_q - CNT_W'(1);
                if (left_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            left_q  <= '0;
            lfsr_q  <= WIDTH'(1);
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            fz_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            left_q  <= left_d;
            lfsr_q  <= lfsr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fz_q    <= fz_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == ST_GEN) || (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign alu_op    = busy ? op_q : 3'b000;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign done      = done_q;
    assign op_err    = err_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_z    = fz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: external ALU (golden or faulty), run-level reference model,
// per-cycle compare against the model, plus hand-computed pins.
module tb_alu_bist;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 8;
    localparam bit SLT_EN = 1'b0;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [2:0]       op_sel;
    logic [CNT_W-1:0] num_vec;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] alu_a, alu_b, alu_z;
    logic [2:0]       alu_op;
    logic             busy, done, op_err;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic [WIDTH-1:0] fail_a, fail_b, fail_z;
    logic [2:0]       dbg_state;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_bist #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SLT_EN(SLT_EN)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .num_vec(num_vec),
        .seed(seed), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
        .busy(busy), .done(done), .op_err(op_err), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .fail_a(fail_a), .fail_b(fail_b), .fail_z(fail_z),
        .dbg_state(dbg_state)
    );

    // Reference arithmetic for each op; SLT is not built, so its result is 0.
    function automatic logic [WIDTH-1:0] ref_z(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    always_comb begin
        alu_z = fault ? (alu_a | alu_b) : ref_z(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: operand pairs, ALU result and verdict per vector.
    logic [WIDTH-1:0] exp_a[256], exp_b[256], exp_z[256];
    bit               exp_ok[256];
    logic [2:0]       m_op;
    bit               m_valid;
    int               m_n;
    int               m_j;
    bit               tracking = 1'b0;

    task automatic model_run(input logic [2:0] op, input int n, input logic [WIDTH-1:0] sd, input bit flt);
        logic [WIDTH-1:0] s;
        m_op    = op;
        m_valid = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
        m_n     = m_valid ? n : 0;
        s       = (sd == 0) ? 32'd1 : sd;
        for (int i = 0; i < m_n; i++) begin
            s        = lfsr_next(s);
            exp_a[i] = s;
            s        = lfsr_next(s);
            exp_b[i] = s;
            exp_z[i] = flt ? (exp_a[i] | exp_b[i]) : ref_z(op, exp_a[i], exp_b[i]);
            exp_ok[i] = (exp_z[i] == ref_z(op, exp_a[i], exp_b[i]));
        end
    endtask

    // Compare process: j counts edges since the start-accept edge (j=0 is that edge).
    int total, checked, pe, fe, first;
    always @(negedge clk) begin
        if (tracking) begin
            total   = 3 * m_n;
            checked = (m_j / 3 < m_n) ? m_j / 3 : m_n;
            pe = 0;
            first = -1;
            for (int i = 0; i < checked; i++) begin
                if (exp_ok[i]) pe++;
                else if (first < 0) first = i;
            end
            fe = checked - pe;
            chk("busy", 32'(busy), 32'(m_j < total));
            chk("done", 32'(done), 32'(m_j >= total));
            chk("op_err", 32'(op_err), 32'(!m_valid));
            chk("alu_op", 32'(alu_op), (m_j < total) ? 32'(m_op) : 32'd0);
            chk("pass_cnt", 32'(pass_cnt), 32'(pe));
            chk("fail_cnt", 32'(fail_cnt), 32'(fe));
            chk("fail_a", fail_a, (first < 0) ? 32'd0 : exp_a[first]);
            chk("fail_b", fail_b, (first < 0) ? 32'd0 : exp_b[first]);
            chk("fail_z", fail_z, (first < 0) ? 32'd0 : exp_z[first]);
            if (m_j >= total) begin
                chk("state", 32'(dbg_state), 32'(ST_DONE));
            end else if (m_j % 3 == 0) begin
                chk("state", 32'(dbg_state), 32'(ST_GEN));
            end else begin
                chk("state", 32'(dbg_state), (m_j % 3 == 1) ? 32'(ST_DRIVE) : 32'(ST_CHECK));
                chk("alu_a", alu_a, exp_a[m_j / 3]);
                chk("alu_b", alu_b, exp_b[m_j / 3]);
            end
            m_j++;
        end
    end

    // Start a run; optionally pulse start mid-run or assert rst after edge rst_at.
    task automatic run(input logic [2:0] op, input int n, input logic [WIDTH-1:0] sd,
                       input bit flt, input int glitch_at, input int rst_at);
        @(negedge clk);
        model_run(op, n, sd, flt);
        fault   = flt;
        op_sel  = op;
        num_vec = CNT_W'(n);
        seed    = sd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        m_j      = 0;
        tracking = 1'b1;
        for (int k = 1; k <= 3 * m_n + 2; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == glitch_at) begin
                start   = 1'b1;
                op_sel  = 3'b011;
                num_vec = CNT_W'(1);
                seed    = 32'h5;
            end
            if (k == rst_at) begin
                tracking = 1'b0;
                chk("pre_rst_state", 32'(dbg_state), 32'(ST_DRIVE));
                chk("pre_rst_pass", 32'(pass_cnt), 32'd1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_pass", 32'(pass_cnt), 32'd0);
                chk("rst_fail", 32'(fail_cnt), 32'd0);
                chk("rst_alu_a", alu_a, 32'd0);
                chk("rst_alu_op", 32'(alu_op), 32'd0);
                chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
                return;
            end
        end
        tracking = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[7];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b101};
        rst = 1'b1; start = 1'b0; op_sel = '0; num_vec = '0; seed = '0; fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass_cnt), 32'd0);
        chk("reset_fail", 32'(fail_cnt), 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        rst = 1'b0;
        chk("model_lfsr", lfsr_next(32'd1), 32'h8020_0003);

        // Golden ALU, ADD, 5 vectors
        run(3'b010, 5, 32'hACE1, 1'b0, -1, -1);
        chk("add_pass", 32'(pass_cnt), 32'd5);
        chk("add_fail", 32'(fail_cnt), 32'd0);

        // Faulty ALU (z = a|b), AND, seed 0 behaves as seed 1
        run(3'b000, 4, 32'd0, 1'b1, -1, -1);
        chk("flt_fail", 32'(fail_cnt), 32'd4);
        chk("flt_a", fail_a, 32'h8020_0003);
        chk("flt_b", fail_b, 32'hC030_0002);
        chk("flt_z", fail_z, 32'hC030_0003);

        // Invalid op, then zero-length run
        run(3'b011, 3, 32'h1234, 1'b0, -1, -1);
        chk("inv_err", 32'(op_err), 32'd1);
        run(3'b001, 0, 32'h9, 1'b0, -1, -1);
        chk("zero_done", 32'(done), 32'd1);

        // SLT not built: golden ALU returns 0, every vector passes
        run(3'b111, 6, 32'hBEEF, 1'b0, -1, -1);
        chk("slt_pass", 32'(pass_cnt), 32'd6);

        // start pulsed while busy is ignored
        run(3'b110, 5, 32'h55AA, 1'b0, 4, -1);

        // rst in DRIVE of vector 2
        run(3'b010, 4, 32'h77, 1'b0, -1, 4);

        for (int r = 0; r < 12; r++) begin
            run(ops[$urandom_range(0, 6)], $urandom_range(0, 10), $urandom,
                1'($urandom_range(0, 1)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
